// File: rtl/enemy_pkg.sv
// Shared types and constants for the enemy slot manager and its per-slot FSMs.
package enemy_pkg;

  localparam int         NUM_SLOTS = 10;
  localparam logic [7:0] Y_EDGE    = 8'd120;
  // Fibonacci taps for x^8 + x^6 + x^5 + x^4 + 1 with bit 7 as the output stage.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLY   = 2'd1,
    CLEAR = 2'd2
  } slot_state_t;

  function automatic logic [7:0] lfsr_step(input logic [7:0] value);
    return {value[6:0], ^(value & LFSR_TAPS)};
  endfunction

  // Folds a value in 0..19 back into the slot index range 0..9.
  function automatic logic [3:0] slot_wrap(input logic [4:0] value);
    return (value >= 5'(NUM_SLOTS)) ? 4'(value - 5'(NUM_SLOTS)) : value[3:0];
  endfunction

endpackage

// File: rtl/enemy_slot_manager_if.sv
// Signal bundle between the game environment (collision/Y-counter side) and the slot manager.
interface enemy_slot_manager_if;
  import enemy_pkg::*;

  logic                 run;
  logic [NUM_SLOTS-1:0] touch_edge;
  logic [NUM_SLOTS-1:0] hit;
  logic [NUM_SLOTS-1:0] c_en;
  logic [NUM_SLOTS-1:0] des;
  logic                 kill_pulse;
  logic                 escape_pulse;
  logic [3:0]           miss_count;
  logic                 game_over;

  modport master (
    output run, touch_edge, hit,
    input  c_en, des, kill_pulse, escape_pulse, miss_count, game_over
  );

  modport slave (
    input  run, touch_edge, hit,
    output c_en, des, kill_pulse, escape_pulse, miss_count, game_over
  );

endinterface

// File: rtl/enemy_slot_fsm.sv
// One enemy slot: IDLE -> FLY on grant, FLY -> CLEAR on hit/escape/forced clear, CLEAR -> IDLE.
module enemy_slot_fsm
  import enemy_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic grant,
  input  logic hit,
  input  logic touch_edge,
  input  logic force_clear,
  output logic c_en,
  output logic des,
  output logic idle,
  output logic killed,
  output logic escaped
);

  slot_state_t state_reg, state_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // killed/escaped flag the transition being taken this cycle; the top registers them.
  always_comb begin
    state_next = state_reg;
    killed     = 1'b0;
    escaped    = 1'b0;
    if (run) begin
      case (state_reg)
        IDLE: begin
          if (grant) state_next = FLY;
        end
        FLY: begin
          if (hit) begin
            state_next = CLEAR;
            killed     = 1'b1;
          end else if (touch_edge) begin
            state_next = CLEAR;
            escaped    = 1'b1;
          end else if (force_clear) begin
            state_next = CLEAR;
          end
        end
        CLEAR:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign c_en = (state_reg == FLY);
  assign des  = (state_reg == CLEAR);
  assign idle = (state_reg == IDLE);

endmodule

// File: rtl/enemy_slot_manager.sv
// Enemy slot lifecycle: spawn timer, LFSR slot picker, miss counter and game-over latch.
module enemy_slot_manager
  import enemy_pkg::*;
#(
  parameter logic [15:0] SPAWN_INTERVAL = 16'd50000,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5,
  parameter logic [3:0]  MAX_MISSES     = 4'd3
) (
  input logic           clk,
  input logic           reset,
  enemy_slot_manager_if.slave bus
);

  logic [15:0]          timer_reg;
  logic [7:0]           lfsr_reg;
  logic [3:0]           miss_reg;
  logic                 game_over_reg;
  logic                 kill_pulse_reg;
  logic                 escape_pulse_reg;
  logic [NUM_SLOTS-1:0] grant, idle, killed, escaped, c_en_vec, des_vec;
  logic                 counting, attempt, found;
  logic [3:0]           start_idx, scan_idx;
  logic [4:0]           miss_sum;

  // An attempt fires on the edge where the count reaches zero, giving exactly
  // SPAWN_INTERVAL counting cycles between attempts.
  assign counting  = bus.run && !game_over_reg;
  assign attempt   = counting && (timer_reg <= 16'd1);
  assign start_idx = slot_wrap({1'b0, lfsr_reg[3:0]});
  assign miss_sum  = {1'b0, miss_reg} + 5'($countones(escaped));

  always_comb begin
    grant    = '0;
    found    = 1'b0;
    scan_idx = '0;
    if (attempt) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        scan_idx = slot_wrap(5'(start_idx) + 5'(i));
        if (!found && idle[scan_idx]) begin
          grant[scan_idx] = 1'b1;
          found           = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_reg        <= SPAWN_INTERVAL;
      lfsr_reg         <= LFSR_SEED;
      miss_reg         <= '0;
      game_over_reg    <= 1'b0;
      kill_pulse_reg   <= 1'b0;
      escape_pulse_reg <= 1'b0;
    end else begin
      // Pulses hold with the frozen slots while paused so they stay aligned with des.
      if (bus.run) begin
        lfsr_reg         <= lfsr_step(lfsr_reg);
        kill_pulse_reg   <= |killed;
        escape_pulse_reg <= |escaped;
        miss_reg         <= (miss_sum > 5'd15) ? 4'd15 : miss_sum[3:0];
      end
      if (counting) begin
        timer_reg <= attempt ? SPAWN_INTERVAL : timer_reg - 16'd1;
      end
      if (miss_reg >= MAX_MISSES) begin
        game_over_reg <= 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      enemy_slot_fsm u_fsm (
        .clk         (clk),
        .reset       (reset),
        .run         (bus.run),
        .grant       (grant[gi]),
        .hit         (bus.hit[gi]),
        .touch_edge  (bus.touch_edge[gi]),
        .force_clear (game_over_reg),
        .c_en        (c_en_vec[gi]),
        .des         (des_vec[gi]),
        .idle        (idle[gi]),
        .killed      (killed[gi]),
        .escaped     (escaped[gi])
      );
    end
  endgenerate

  assign bus.c_en         = c_en_vec;
  assign bus.des          = des_vec;
  assign bus.kill_pulse   = kill_pulse_reg;
  assign bus.escape_pulse = escape_pulse_reg;
  assign bus.miss_count   = miss_reg;
  assign bus.game_over    = game_over_reg;

endmodule

// File: tb/tb_enemy_slot_manager.sv
// Directed plus randomized checks of enemy_slot_manager against a cycle-level slot model.
module tb_enemy_slot_manager;

  localparam int SI = 8;

  logic clk;
  logic reset;
  enemy_slot_manager_if bus ();

  enemy_slot_manager #(
    .SPAWN_INTERVAL (16'(SI)),
    .LFSR_SEED      (8'hA5),
    .MAX_MISSES     (4'd3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Model: each slot is either parked, flying, or spending its one clear cycle.
  bit         m_fly [10];
  bit         m_clr [10];
  int         m_timer;
  logic [7:0] m_lfsr;
  int         m_miss;
  bit         m_go, m_kp, m_ep;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] exp_c_en();
    logic [9:0] v;
    for (int i = 0; i < 10; i++) v[i] = m_fly[i];
    return v;
  endfunction

  function automatic logic [9:0] exp_des();
    logic [9:0] v;
    for (int i = 0; i < 10; i++) v[i] = m_clr[i];
    return v;
  endfunction

  task automatic model_step();
    logic [9:0] h, t;
    logic [7:0] ol;
    bit         r, ogo;
    int         omiss, esc, kil, g, s;
    h = bus.hit;
    t = bus.touch_edge;
    r = bus.run;
    if (reset) begin
      for (int i = 0; i < 10; i++) begin
        m_fly[i] = 1'b0;
        m_clr[i] = 1'b0;
      end
      m_timer = SI;
      m_lfsr  = 8'hA5;
      m_miss  = 0;
      m_go    = 1'b0;
      m_kp    = 1'b0;
      m_ep    = 1'b0;
      return;
    end
    ogo   = m_go;
    omiss = m_miss;
    ol    = m_lfsr;
    g     = -1;
    if (r && !ogo) begin
      m_timer = m_timer - 1;
      if (m_timer == 0) begin
        s = int'(ol[3:0]);
        if (s >= 10) s = s - 10;
        for (int k = 0; k < 10; k++) begin
          if (g < 0 && !m_fly[(s + k) % 10] && !m_clr[(s + k) % 10]) g = (s + k) % 10;
        end
        m_timer = SI;
      end
    end
    if (r) begin
      esc = 0;
      kil = 0;
      for (int i = 0; i < 10; i++) begin
        if (m_clr[i]) begin
          m_clr[i] = 1'b0;
        end else if (m_fly[i]) begin
          if (h[i]) kil++;
          else if (t[i]) esc++;
          if (h[i] || t[i] || ogo) begin
            m_fly[i] = 1'b0;
            m_clr[i] = 1'b1;
          end
        end else if (i == g) begin
          m_fly[i] = 1'b1;
        end
      end
      m_kp   = (kil > 0);
      m_ep   = (esc > 0);
      m_miss = (m_miss + esc > 15) ? 15 : m_miss + esc;
      m_lfsr = {ol[6:0], ol[7] ^ ol[5] ^ ol[4] ^ ol[3]};
    end
    if (omiss >= 3) m_go = 1'b1;
  endtask

  task automatic check_all();
    check("c_en",         bus.c_en,         exp_c_en());
    check("des",          bus.des,          exp_des());
    check("kill_pulse",   bus.kill_pulse,   m_kp);
    check("escape_pulse", bus.escape_pulse, m_ep);
    check("miss_count",   bus.miss_count,   m_miss);
    check("game_over",    bus.game_over,    m_go);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  logic [9:0] snap;
  int         guard;

  initial begin
    reset          = 1'b1;
    bus.run        = 1'b1;
    bus.hit        = '0;
    bus.touch_edge = '0;
    repeat (3) tick();
    check("reset_c_en", bus.c_en, 10'h000);
    check("reset_des",  bus.des,  10'h000);

    // First spawn lands exactly SPAWN_INTERVAL cycles after reset release.
    reset = 1'b0;
    for (int k = 0; k < SI - 1; k++) begin
      tick();
      check("pre_spawn_c_en", bus.c_en, 10'h000);
    end
    tick();
    check("first_spawn_onehot", $countones(bus.c_en), 1);

    // Fill every slot, then confirm an attempt on a full board changes nothing.
    guard = 0;
    while (bus.c_en != 10'h3FF && guard < 300) begin
      tick();
      guard++;
    end
    check("fill_done", bus.c_en, 10'h3FF);
    for (int k = 0; k < SI + 2; k++) begin
      tick();
      check("full_no_change", bus.c_en, 10'h3FF);
    end

    // Free only slot 9; the next attempt must pick it wherever the scan starts.
    bus.hit[9] = 1'b1;
    tick();
    bus.hit = '0;
    check("slot9_kill_des", bus.des[9], 1'b1);
    guard = 0;
    while (!bus.c_en[9] && guard < 3 * SI) begin
      tick();
      guard++;
    end
    check("slot9_regrant", bus.c_en, 10'h3FF);

    // Escape on slot 3.
    bus.touch_edge[3] = 1'b1;
    tick();
    bus.touch_edge = '0;
    check("esc3_c_en", bus.c_en[3], 1'b0);
    check("esc3_des", bus.des[3], 1'b1);
    check("esc3_pulse", bus.escape_pulse, 1'b1);
    check("esc3_miss", bus.miss_count, 4'd1);
    tick();
    check("esc3_des_fall", bus.des[3], 1'b0);
    check("esc3_c_en_low", bus.c_en[3], 1'b0);

    // Hit and escape together on slot 5 count as a kill only.
    bus.hit[5]        = 1'b1;
    bus.touch_edge[5] = 1'b1;
    tick();
    bus.hit        = '0;
    bus.touch_edge = '0;
    check("both5_kill", bus.kill_pulse, 1'b1);
    check("both5_esc", bus.escape_pulse, 1'b0);
    check("both5_miss", bus.miss_count, 4'd1);

    // Two escapes together reach the limit.
    bus.touch_edge[2] = 1'b1;
    bus.touch_edge[7] = 1'b1;
    tick();
    bus.touch_edge = '0;
    check("double_esc_miss", bus.miss_count, 4'd3);
    check("go_not_yet", bus.game_over, 1'b0);
    tick();
    check("go_rise", bus.game_over, 1'b1);
    snap = bus.c_en;
    tick();
    check("go_clear_des", bus.des, snap);
    check("go_clear_c_en", bus.c_en, 10'h000);
    tick();
    check("go_des_fall", bus.des, 10'h000);
    for (int k = 0; k < 30; k++) begin
      tick();
      check("go_no_spawn", bus.c_en, 10'h000);
    end

    // Pause mid-flight: everything freezes, hits and escapes are ignored.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (30) tick();
    snap = bus.c_en;
    bus.run = 1'b0;
    for (int k = 0; k < 100; k++) begin
      bus.hit        = 10'($urandom);
      bus.touch_edge = 10'($urandom);
      tick();
      check("pause_hold", bus.c_en, snap);
    end
    bus.run        = 1'b1;
    bus.hit        = '0;
    bus.touch_edge = '0;
    repeat (40) tick();

    // Reset mid-flight returns everything to reset values after one edge.
    reset = 1'b1;
    tick();
    check("midreset_c_en", bus.c_en, 10'h000);
    check("midreset_des", bus.des, 10'h000);
    check("midreset_miss", bus.miss_count, 4'd0);
    check("midreset_go", bus.game_over, 1'b0);
    reset = 1'b0;

    // Randomized segments, each starting from reset.
    for (int seg = 0; seg < 8; seg++) begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int k = 0; k < 250; k++) begin
        bus.run = ($urandom_range(0, 99) < 90);
        for (int i = 0; i < 10; i++) begin
          bus.hit[i]        = ($urandom_range(0, 99) < 4);
          bus.touch_edge[i] = ($urandom_range(0, 199) < 1);
        end
        tick();
      end
    end
    bus.run        = 1'b1;
    bus.hit        = '0;
    bus.touch_edge = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
